// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: owner and FSM encodings plus default widths shared by the SDRAM port arbiter.
package sdram_arb_pkg;
   localparam int DEF_ADDR_W = 24;
   localparam int DEF_LEN_W = 9;
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_QSPI = 2'd1;
   localparam logic [1:0] OWN_USB = 2'd2;
   localparam logic [1:0] OWN_REF = 2'd3;
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} state_e;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester, controller command and owner signals of the SDRAM port arbiter.
interface sdram_port_arbiter_if
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W = DEF_LEN_W
) ();
   logic              sdram_init_done;
   logic              qspi_req, qspi_wr, qspi_gnt, qspi_done;
   logic [ADDR_W-1:0] qspi_addr;
   logic [LEN_W-1:0]  qspi_len;
   logic              usb_req, usb_wr, usb_gnt, usb_done;
   logic [ADDR_W-1:0] usb_addr;
   logic [LEN_W-1:0]  usb_len;
   logic              ctrl_cmd_valid, ctrl_cmd_ready, ctrl_cmd_wr, ctrl_cmd_ref, ctrl_done;
   logic [ADDR_W-1:0] ctrl_cmd_addr;
   logic [LEN_W-1:0]  ctrl_cmd_len;
   logic [1:0]        owner;
   modport slave (
      input  sdram_init_done, qspi_req, qspi_wr, qspi_addr, qspi_len,
             usb_req, usb_wr, usb_addr, usb_len, ctrl_cmd_ready, ctrl_done,
      output qspi_gnt, qspi_done, usb_gnt, usb_done, ctrl_cmd_valid, ctrl_cmd_wr,
             ctrl_cmd_ref, ctrl_cmd_addr, ctrl_cmd_len, owner
   );
   modport master (
      output sdram_init_done, qspi_req, qspi_wr, qspi_addr, qspi_len,
             usb_req, usb_wr, usb_addr, usb_len, ctrl_cmd_ready, ctrl_done,
      input  qspi_gnt, qspi_done, usb_gnt, usb_done, ctrl_cmd_valid, ctrl_cmd_wr,
             ctrl_cmd_ref, ctrl_cmd_addr, ctrl_cmd_len, owner
   );
endinterface

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: counts sd_clk cycles once init is done and keeps up to two refreshes pending.
module sdram_ref_timer #(
   parameter int REF_INTERVAL = 780
) (
   input  logic sd_clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic ack_i,
   output logic pend_o
);
   localparam int TW = $clog2(REF_INTERVAL + 1);
   localparam logic [TW-1:0] LAST = TW'(REF_INTERVAL - 1);
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    backlog_q, backlog_d;
   logic          expire;
   always_comb begin
      expire = en_i && timer_q == LAST;
      timer_d = !en_i ? timer_q : expire ? '0 : timer_q + TW'(1);
      backlog_d = backlog_q - 2'(ack_i && backlog_q != 2'd0);
      backlog_d = backlog_d + 2'(expire && backlog_d != 2'd2);
   end
   always_ff @(posedge sd_clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
         backlog_q <= 2'd0;
      end else begin
         timer_q <= timer_d;
         backlog_q <= backlog_d;
      end
   end
   assign pend_o = backlog_q != 2'd0;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller command port between QSPI and USB requesters.
// Periodic auto-refresh scheduling is built only when SDRAM_ARB_AUTO_REF_EN is defined.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W = DEF_LEN_W,
   parameter int MAX_QSPI_RUN = 4,
   parameter int REF_INTERVAL = 780
) (
   input logic sd_clk,
   input logic rst_n,
   sdram_port_arbiter_if.slave bus
);
   localparam int RW = $clog2(MAX_QSPI_RUN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(MAX_QSPI_RUN);
   state_e            state_q;
   logic [1:0]        owner_q, pick_d;
   logic [RW-1:0]     run_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic              valid_q, wr_q, ref_q, qspi_gnt_q, usb_gnt_q, qspi_done_q, usb_done_q;
   logic              ref_pend, fin_d;
`ifdef SDRAM_ARB_AUTO_REF_EN
   sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref (
      .sd_clk(sd_clk),
      .rst_n(rst_n),
      .en_i(bus.sdram_init_done),
      .ack_i(state_q == IDLE && pick_d == OWN_REF),
      .pend_o(ref_pend)
   );
`else
   logic unused_ref;
   assign ref_pend = 1'b0;
   assign unused_ref = REF_INTERVAL != 0;
`endif
   // Refresh first, then a forced USB turn once QSPI has used up its run, then QSPI over USB.
   always_comb begin
      pick_d = !bus.sdram_init_done ? OWN_NONE :
               ref_pend ? OWN_REF :
               (bus.usb_req && run_q == RUN_MAX) ? OWN_USB :
               bus.qspi_req ? OWN_QSPI :
               bus.usb_req ? OWN_USB : OWN_NONE;
      fin_d = bus.ctrl_done && (state_q == BUSY || (state_q == ISSUE && bus.ctrl_cmd_ready));
   end
   always_ff @(posedge sd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= OWN_NONE;
         run_q <= '0;
         addr_q <= '0;
         len_q <= '0;
         valid_q <= 1'b0;
         wr_q <= 1'b0;
         ref_q <= 1'b0;
         qspi_gnt_q <= 1'b0;
         usb_gnt_q <= 1'b0;
         qspi_done_q <= 1'b0;
         usb_done_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus.usb_req) run_q <= '0;
               if (pick_d != OWN_NONE) begin
                  state_q <= ISSUE;
                  owner_q <= pick_d;
                  valid_q <= 1'b1;
                  ref_q <= pick_d == OWN_REF;
                  qspi_gnt_q <= pick_d == OWN_QSPI;
                  usb_gnt_q <= pick_d == OWN_USB;
                  wr_q <= pick_d == OWN_QSPI ? bus.qspi_wr : pick_d == OWN_USB && bus.usb_wr;
                  addr_q <= pick_d == OWN_QSPI ? bus.qspi_addr : pick_d == OWN_USB ? bus.usb_addr : '0;
                  len_q <= pick_d == OWN_QSPI ? bus.qspi_len : pick_d == OWN_USB ? bus.usb_len : '0;
                  if (pick_d == OWN_USB) run_q <= '0;
                  else if (pick_d == OWN_QSPI && bus.usb_req && run_q != RUN_MAX) run_q <= run_q + RW'(1);
               end
            end
            ISSUE: if (bus.ctrl_cmd_ready) begin
               valid_q <= 1'b0;
               state_q <= bus.ctrl_done ? RELEASE : BUSY;
            end
            BUSY: if (bus.ctrl_done) state_q <= RELEASE;
            default: begin
               qspi_done_q <= 1'b0;
               usb_done_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
         // Done pulses appear during RELEASE, together with the grant drop.
         if (fin_d) begin
            qspi_done_q <= owner_q == OWN_QSPI;
            usb_done_q <= owner_q == OWN_USB;
            qspi_gnt_q <= 1'b0;
            usb_gnt_q <= 1'b0;
            owner_q <= OWN_NONE;
            ref_q <= 1'b0;
         end
      end
   end
   assign bus.qspi_gnt = qspi_gnt_q;
   assign bus.usb_gnt = usb_gnt_q;
   assign bus.qspi_done = qspi_done_q;
   assign bus.usb_done = usb_done_q;
   assign bus.ctrl_cmd_valid = valid_q;
   assign bus.ctrl_cmd_wr = wr_q;
   assign bus.ctrl_cmd_ref = ref_q;
   assign bus.ctrl_cmd_addr = addr_q;
   assign bus.ctrl_cmd_len = len_q;
   assign bus.owner = owner_q;
endmodule
